// File: rtl/store_buffer_pkg.sv
// rtl/store_buffer_pkg.sv - shared types and default sizes for the store buffer
package store_buffer_pkg;

  localparam int SB_DEPTH  = 4;
  localparam int SB_ADDR_W = 32;
  localparam int SB_DATA_W = 32;

  typedef struct packed {
    logic [SB_ADDR_W-1:0] addr;
    logic [SB_DATA_W-1:0] data;
  } sb_entry_t;

  typedef enum logic {
    SB_RUN,
    SB_FLUSH
  } sb_state_t;

endpackage

// File: rtl/sb_forward_match.sv
// rtl/sb_forward_match.sv - youngest-entry address match for load forwarding
module sb_forward_match #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0][ADDR_W-1:0] ent_addr,
  input  logic [DEPTH-1:0][DATA_W-1:0] ent_data,
  input  logic [DEPTH-1:0]             valid,
  input  logic [PTR_W-1:0]             wr_ptr,
  input  logic [ADDR_W-1:0]            addr,
  output logic                         hit,
  output logic [DATA_W-1:0]            data
);

  logic [PTR_W-1:0] idx;

  // Walk oldest to youngest so the youngest match overwrites earlier ones.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      idx = wr_ptr - PTR_W'(k + 1);
      if (valid[idx] && (ent_addr[idx] == addr)) begin
        hit  = 1'b1;
        data = ent_data[idx];
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - posted-write buffer with load forwarding and flush fence
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH  = SB_DEPTH,
  parameter int ADDR_W = SB_ADDR_W,
  parameter int DATA_W = SB_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_mem_write,
  input  logic              cpu_mem_read,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              stall,
  input  logic              flush_req,
  output logic              empty,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DEPTH-1:0][ADDR_W-1:0] ent_addr;
  logic [DEPTH-1:0][DATA_W-1:0] ent_data;
  logic [DEPTH-1:0]             valid;
  logic [PTR_W-1:0]             wr_ptr, rd_ptr, off;
  logic [CNT_W-1:0]             count, count_next;
  sb_state_t                    state;

  logic              flushing, req_read, req_write, load_miss;
  logic              drain, enq, full, fwd_hit;
  logic [DATA_W-1:0] fwd_data;

  // An entry is live if its distance from the head is below count.
  always_comb begin
    valid = '0;
    off   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off      = PTR_W'(i) - rd_ptr;
      valid[i] = CNT_W'(off) < count;
    end
  end

  sb_forward_match #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_match (
    .ent_addr(ent_addr),
    .ent_data(ent_data),
    .valid   (valid),
    .wr_ptr  (wr_ptr),
    .addr    (cpu_addr),
    .hit     (fwd_hit),
    .data    (fwd_data)
  );

  // The fence stalls from the request cycle itself so no new op slips in.
  assign flushing  = (state == SB_FLUSH) || (flush_req && (count != '0));
  assign req_read  = cpu_mem_read && !flushing;
  assign req_write = cpu_mem_write && !flushing;
  assign load_miss = req_read && !fwd_hit;
  assign full      = (count == CNT_W'(DEPTH));
  assign drain     = (count != '0) && mem_ready && !load_miss;
  assign enq       = req_write && (!full || drain);

  assign empty     = (count == '0);
  assign mem_read  = load_miss && mem_ready;
  assign mem_write = drain;
  assign stall     = flushing || (load_miss && !mem_ready) || (req_write && !enq);
  assign mem_addr  = mem_read ? cpu_addr : (drain ? ent_addr[rd_ptr] : '0);
  assign mem_wdata = drain ? ent_data[rd_ptr] : '0;
  assign cpu_rdata = (req_read && fwd_hit) ? fwd_data : (mem_read ? mem_rdata : '0);

  always_comb begin
    count_next = count;
    case ({enq, drain})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      ent_addr[wr_ptr] <= cpu_addr;
      ent_data[wr_ptr] <= cpu_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      state  <= SB_RUN;
    end else begin
      if (enq)   wr_ptr <= wr_ptr + 1'b1;
      if (drain) rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
      case (state)
        SB_RUN:   if (flush_req && (count_next != '0)) state <= SB_FLUSH;
        SB_FLUSH: if (count_next == '0) state <= SB_RUN;
        default:  state <= SB_RUN;
      endcase
    end
  end

endmodule
